// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr
// Round-robin arbiter sharing one Wishbone slave port among MASTERS masters.
// A master keeps the slave for its whole bus cycle (grant until it drops cyc),
// so registered-feedback bursts are never split between owners. After an owner
// leaves there is always one idle cycle before the next grant, and the search
// for the next owner starts just past the previous winner.

module wb_arbiter_rr #(
  parameter int MASTERS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  // master side
  input  logic [MASTERS-1:0]                m_cyc_i,
  input  logic [MASTERS-1:0]                m_stb_i,
  input  logic [MASTERS-1:0]                m_we_i,
  input  logic [MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  input  logic [MASTERS*3-1:0]              m_cti_i,
  input  logic [MASTERS*2-1:0]              m_bte_i,
  output logic [MASTERS-1:0]                m_ack_o,
  output logic [MASTERS-1:0]                m_err_o,
  output logic [MASTERS-1:0]                m_rty_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,

  // slave side
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [DATA_WIDTH/8-1:0]           s_sel_o,
  output logic [2:0]                        s_cti_o,
  output logic [1:0]                        s_bte_o,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,

  // current owner, one-hot; zero while idle
  output logic [MASTERS-1:0]                grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  localparam logic [MASTERS-1:0] GRANT_ONE = {{(MASTERS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(MASTERS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [MASTERS-1:0] grant_r;
  logic [MASTERS-1:0] grant_nxt_s;
  logic [IDX_W-1:0]   last_r;
  logic [IDX_W-1:0]   last_nxt_s;

  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               owner_cyc_s;
  logic               busy_s;

  assign grant_o = grant_r;

  // Read data needs no steering: only the owner is waiting for it.
  assign m_dat_o = s_dat_i;

  // Winner search: first requester at or after last_r+1, wrapping at MASTERS.
  always_comb begin
    int               cand_v;
    logic [IDX_W-1:0] cand_idx_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_v      = 0;
    cand_idx_v  = '0;
    for (int i = 1; i <= MASTERS; i++) begin
      cand_v     = (int'(last_r) + i) % MASTERS;
      cand_idx_v = IDX_W'(cand_v);
      if (!win_found_s && m_cyc_i[cand_idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_idx_v;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Sequential state: FSM state, grant register and last-winner pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      last_r  <= LAST_RST;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next state: grant on any request while idle, release when the owner drops cyc.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    owner_cyc_s = |(m_cyc_i & grant_r);
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s = ST_BUSY;
          grant_nxt_s = GRANT_ONE << win_idx_s;
          last_nxt_s  = win_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end
      end
      ST_BUSY: begin
        // Other requests are deliberately ignored here; release has priority
        // and arbitration only happens from IDLE on the following cycle.
        if (!owner_cyc_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // Outputs: AND-OR forward mux selected by the one-hot grant, and response
  // routing back to the owner only; everything reads zero while idle.
  always_comb begin
    busy_s  = (state_r == ST_BUSY);
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    for (int k = 0; k < MASTERS; k++) begin
      if (busy_s && grant_r[k]) begin
        s_cyc_o = s_cyc_o | m_cyc_i[k];
        s_stb_o = s_stb_o | m_stb_i[k];
        s_we_o  = s_we_o  | m_we_i[k];
        s_adr_o = s_adr_o | m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o = s_dat_o | m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o = s_sel_o | m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
        s_cti_o = s_cti_o | m_cti_i[k*3 +: 3];
        s_bte_o = s_bte_o | m_bte_i[k*2 +: 2];
      end else begin
        s_cyc_o = s_cyc_o;
      end
    end
    if (busy_s) begin
      m_ack_o = grant_r & {MASTERS{s_ack_i}};
      m_err_o = grant_r & {MASTERS{s_err_i}};
      m_rty_o = grant_r & {MASTERS{s_rty_i}};
    end else begin
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
    end
  end

endmodule
